// File: rtl/am2954_fifo.sv
// ============================================================================
// Module   : am2954_fifo
// Purpose  : WIDTH x DEPTH synchronous FIFO with a registered tristate output,
//            full/empty status, sticky error flag and asynchronous clear.
//            Optional half-full flag is enabled by defining AM2954_FIFO_HALF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module am2954_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             cp,
  input  logic             clr_,
  input  logic [WIDTH-1:0] d,
  input  logic             we_,
  input  logic             re_,
  input  logic             oe_,
  output wire  [WIDTH-1:0] y,
  output logic             empty,
  output logic             full,
  output logic             err
`ifdef AM2954_FIFO_HALF_EN
  ,
  output logic             half
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic             rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign err   = err_q;

`ifdef AM2954_FIFO_HALF_EN
  assign half  = (cnt_q >= CNT_W'(DEPTH / 2));
`endif

  assign y = oe_ ? {WIDTH{1'bz}} : q_q;

  always_comb begin
    // A write into a full FIFO is accepted only when a read frees a slot
    // on the same edge; a read from an empty FIFO never falls through.
    wr_en = !we_ && (!full || !re_);
    rd_en = !re_ && !empty;

    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    err_d = err_q;

    if (wr_en) begin
      wp_d = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
    end

    if (rd_en) begin
      rp_d = (rp_q == PTR_W'(DEPTH - 1)) ? '0 : rp_q + PTR_W'(1);
      q_d  = mem[rp_q];
    end

    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if ((!we_ && !wr_en) || (!re_ && !rd_en)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge cp or negedge clr_) begin
    if (!clr_) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  // Storage is deliberately left uninitialised by clear.
  always_ff @(posedge cp) begin
    if (wr_en) begin
      mem[wp_q] <= d;
    end
  end

endmodule

`default_nettype wire
